// File: rtl/mem_scheduler_pkg.sv
// mem_scheduler_pkg: shared memory request/response types and scheduler enums
package mem_scheduler_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;
    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_ready;
    } mem_out_type;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D, OWN_X} sched_owner_type;
    typedef enum logic {IDLE, BUSY} sched_state_type;
    localparam mem_in_type MEM_IN_IDLE = '0;
endpackage

// File: rtl/mem_pending_slot.sv
// mem_pending_slot: one-entry request buffer for a single requester
// req/en: incoming pulse and port enable; clr: head granted this cycle; flush: drop all
// head: pending entry, or the arriving request when the slot is empty; ovr: arrival dropped
module mem_pending_slot
    import mem_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  mem_in_type req,
    input  logic       en,
    input  logic       clr,
    input  logic       flush,
    output mem_in_type head,
    output logic       ovr
);
    mem_in_type pend;
    logic take;
    // An arrival on an empty slot is offered straight to the arbiter so an idle
    // bus can issue it at the very edge it arrives.
    always_comb begin
        take = req.mem_valid & en & ~flush;
        head = flush ? MEM_IN_IDLE : pend.mem_valid ? pend : take ? req : MEM_IN_IDLE;
        ovr = take & pend.mem_valid & ~clr;
    end
    // A grant of a stored entry frees the slot for the arrival in the same cycle;
    // a grant of a bypassed arrival leaves the slot empty.
    always_ff @(posedge clk)
        if (!rst || flush) pend <= MEM_IN_IDLE;
        else if (clr) pend <= (pend.mem_valid & take) ? req : MEM_IN_IDLE;
        else if (take & ~pend.mem_valid) pend <= req;
endmodule

// File: rtl/mem_scheduler.sv
// mem_scheduler: shares one memory port between fetch, load/store and an external master
// imem/dmem/xmem_in/_out: requester pulses and responses; flush_instr: cancel fetch traffic
// memory_*: registered bus request, combinational response; overrun: sticky dropped request
module mem_scheduler
    import mem_scheduler_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter bit XMEM_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    input  mem_in_type  xmem_in,
    output mem_out_type xmem_out,
    input  logic        flush_instr,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        overrun
);
    localparam int AW = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_MAX);
    mem_in_type i_head, d_head, x_head, win_req;
    logic i_ovr, d_ovr, x_ovr, done, issue, waiting, ptr, drop;
    logic [AW-1:0] age;
    sched_state_type state, state_n;
    sched_owner_type owner, owner_n, win;

    mem_pending_slot u_islot (.clk(clk), .rst(rst), .req(imem_in), .en(1'b1),
        .clr(issue && win == OWN_I), .flush(flush_instr), .head(i_head), .ovr(i_ovr));
    mem_pending_slot u_dslot (.clk(clk), .rst(rst), .req(dmem_in), .en(1'b1),
        .clr(issue && win == OWN_D), .flush(1'b0), .head(d_head), .ovr(d_ovr));
    mem_pending_slot u_xslot (.clk(clk), .rst(rst), .req(xmem_in), .en(XMEM_EN),
        .clr(issue && win == OWN_X), .flush(1'b0), .head(x_head), .ovr(x_ovr));

    // ptr=0 favours imem, ptr=1 favours xmem; dmem wins unless a waiter has aged out.
    always_comb begin
        waiting = i_head.mem_valid | x_head.mem_valid;
        done = (state == BUSY) & memory_ready;
        issue = ((state == IDLE) | done) & (waiting | d_head.mem_valid);
        win = (d_head.mem_valid & ~(waiting & (age == AGE_MAX))) ? OWN_D :
              (i_head.mem_valid & (~x_head.mem_valid | ~ptr)) ? OWN_I :
              x_head.mem_valid ? OWN_X : OWN_NONE;
        win_req = (win == OWN_I) ? i_head : (win == OWN_X) ? x_head : d_head;
        state_n = issue ? BUSY : done ? IDLE : state;
        owner_n = issue ? win : done ? OWN_NONE : owner;
        imem_out = '0;
        dmem_out = '0;
        xmem_out = '0;
        imem_out.mem_ready = done & (owner == OWN_I) & ~drop & ~flush_instr;
        dmem_out.mem_ready = done & (owner == OWN_D);
        xmem_out.mem_ready = done & (owner == OWN_X);
        imem_out.mem_rdata = imem_out.mem_ready ? memory_rdata : 32'h0;
        dmem_out.mem_rdata = dmem_out.mem_ready ? memory_rdata : 32'h0;
        xmem_out.mem_rdata = xmem_out.mem_ready ? memory_rdata : 32'h0;
    end

    always_ff @(posedge clk)
        if (!rst) begin
            state <= IDLE;
            owner <= OWN_NONE;
            memory_valid <= 1'b0;
            memory_instr <= 1'b0;
            memory_addr <= '0;
            memory_wdata <= '0;
            memory_wstrb <= '0;
            age <= '0;
            ptr <= 1'b0;
            drop <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            if (issue) begin
                memory_valid <= win_req.mem_valid;
                memory_instr <= win_req.mem_instr;
                memory_addr <= win_req.mem_addr;
                memory_wdata <= win_req.mem_wdata;
                memory_wstrb <= win_req.mem_wstrb;
            end else if (done) memory_valid <= 1'b0;
            if (issue && win != OWN_D) ptr <= (win == OWN_I);
            age <= ~waiting ? '0 : ~issue ? age : (win != OWN_D) ? '0 :
                   (age == AGE_MAX) ? age : age + 1'b1;
            // A flushed fetch still runs to completion on the bus; only its response is hidden.
            drop <= ~done & (drop | (flush_instr & (state == BUSY) & (owner == OWN_I)));
            overrun <= overrun | i_ovr | d_ovr | x_ovr;
        end
endmodule

// File: tb/tb_mem_scheduler.sv
// tb_mem_scheduler: vector table, directed corner sequences and randomized model check
module tb_mem_scheduler;
    import mem_scheduler_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    mem_in_type imem_in, dmem_in, xmem_in;
    mem_out_type imem_out, dmem_out, xmem_out;
    logic flush_instr, memory_valid, memory_instr, memory_ready, overrun;
    logic [31:0] memory_addr, memory_wdata, memory_rdata;
    logic [3:0] memory_wstrb;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_model = 1'b0;

    always #5 clk = ~clk;

    mem_scheduler dut (
        .clk(clk), .rst(rst),
        .imem_in(imem_in), .imem_out(imem_out),
        .dmem_in(dmem_in), .dmem_out(dmem_out),
        .xmem_in(xmem_in), .xmem_out(xmem_out),
        .flush_instr(flush_instr),
        .memory_valid(memory_valid), .memory_instr(memory_instr),
        .memory_addr(memory_addr), .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb),
        .memory_rdata(memory_rdata), .memory_ready(memory_ready),
        .overrun(overrun)
    );

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] rdata;
        logic        exp_instr;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic mem_in_type mk(input logic instr, input logic [31:0] a, input logic [31:0] w,
                                      input logic [3:0] s);
        mk = '{1'b1, instr, a, w, s};
    endfunction

    task automatic clear_req;
        imem_in = MEM_IN_IDLE;
        dmem_in = MEM_IN_IDLE;
        xmem_in = MEM_IN_IDLE;
        flush_instr = 1'b0;
    endtask

    task automatic pulse(input int p, input mem_in_type r);
        if (p == 0) imem_in = r;
        else if (p == 1) dmem_in = r;
        else xmem_in = r;
    endtask

    task automatic do_reset;
        clear_req();
        memory_ready = 1'b0;
        memory_rdata = 32'h0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic chk_bus(input string t, input logic v, input logic instr, input logic [31:0] a,
                           input logic [31:0] w, input logic [3:0] s);
        if (v) check(t, {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb},
                     {v, instr, a, w, s});
        else check(t, memory_valid, 1'b0);
    endtask

    task automatic chk_resp(input string t, input int p, input logic [31:0] rd);
        logic [2:0] er;
        er = {p == 0, p == 1, p == 2};
        check({t, "_rdy"}, {imem_out.mem_ready, dmem_out.mem_ready, xmem_out.mem_ready}, er);
        check({t, "_rdata"}, {imem_out.mem_rdata, dmem_out.mem_rdata, xmem_out.mem_rdata},
              {er[2] ? rd : 32'h0, er[1] ? rd : 32'h0, er[0] ? rd : 32'h0});
    endtask

    // Reference model: per-port queues; arrivals join, a winner pops, any queue left
    // holding two entries loses its newest one (overrun).
    mem_in_type mq[3][$];
    mem_in_type m_bus;
    bit m_busy, m_drop, m_ovr;
    int m_own, m_age, m_rr;

    always @(negedge clk) begin
        mem_in_type inc[3];
        bit done, waiting;
        int w;
        logic [2:0] er;
        inc = '{imem_in, dmem_in, xmem_in};
        done = m_busy && memory_ready;
        er = {done && m_own == 0 && !m_drop && !flush_instr, done && m_own == 1, done && m_own == 2};
        if (chk_model) begin
            check("m_valid", memory_valid, m_busy);
            if (m_busy) check("m_bus", {memory_instr, memory_addr, memory_wdata, memory_wstrb},
                              {m_bus.mem_instr, m_bus.mem_addr, m_bus.mem_wdata, m_bus.mem_wstrb});
            check("m_ready", {imem_out.mem_ready, dmem_out.mem_ready, xmem_out.mem_ready}, er);
            check("m_rdata", {imem_out.mem_rdata, dmem_out.mem_rdata, xmem_out.mem_rdata},
                  {er[2] ? memory_rdata : 32'h0, er[1] ? memory_rdata : 32'h0, er[0] ? memory_rdata : 32'h0});
            check("m_overrun", overrun, m_ovr);
        end
        if (!rst) begin
            for (int p = 0; p < 3; p++) mq[p].delete();
            m_busy = 0; m_drop = 0; m_ovr = 0; m_own = -1; m_age = 0; m_rr = 0;
        end else begin
            m_drop = done ? 1'b0 : (m_drop || (flush_instr && m_busy && m_own == 0));
            for (int p = 0; p < 3; p++) if (inc[p].mem_valid) mq[p].push_back(inc[p]);
            if (flush_instr) mq[0].delete();
            waiting = mq[0].size() != 0 || mq[2].size() != 0;
            w = -1;
            if (!m_busy || memory_ready) begin
                if (mq[1].size() != 0 && !(m_age == 8 && waiting)) w = 1;
                else if (mq[0].size() != 0 && mq[2].size() != 0) w = (m_rr == 0) ? 0 : 2;
                else if (mq[0].size() != 0) w = 0;
                else if (mq[2].size() != 0) w = 2;
            end
            if (w >= 0) begin
                m_bus = mq[w].pop_front();
                m_busy = 1;
                m_own = w;
                if (w == 1) m_age = waiting ? ((m_age < 8) ? m_age + 1 : 8) : 0;
                else begin
                    m_age = 0;
                    m_rr = (w == 0) ? 1 : 0;
                end
            end else begin
                if (done) begin
                    m_busy = 0;
                    m_own = -1;
                end
                if (!waiting) m_age = 0;
            end
            for (int p = 0; p < 3; p++)
                if (mq[p].size() > 1) begin
                    void'(mq[p].pop_back());
                    m_ovr = 1;
                end
        end
    end

    initial begin
        vt[0] = '{1, 32'h100, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
        vt[1] = '{0, 32'h2000, 32'h0, 4'h0, 1, 32'h00000013, 1'b1, 32'h00000013};
        vt[2] = '{2, 32'h3000, 32'hCAFEF00D, 4'hF, 2, 32'h0, 1'b0, 32'h0};
        vt[3] = '{1, 32'h104, 32'h0000AB00, 4'h2, 0, 32'h11112222, 1'b0, 32'h11112222};
        vt[4] = '{2, 32'h40, 32'h0, 4'h0, 3, 32'h12345678, 1'b0, 32'h12345678};

        clear_req();
        memory_ready = 1'b0;
        memory_rdata = 32'h0;
        tick();
        tick();
        @(negedge clk);
        check("rst_bus", {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb}, 70'h0);
        check("rst_overrun", overrun, 1'b0);
        chk_resp("rst", -1, 32'h0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            pulse(vt[i].port, mk(vt[i].port == 0, vt[i].addr, vt[i].wdata, vt[i].wstrb));
            @(negedge clk);
            chk_bus("vec_idle", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            tick();
            clear_req();
            for (int w = 0; w < vt[i].waits; w++) begin
                @(negedge clk);
                chk_bus("vec_wait", 1'b1, vt[i].exp_instr, vt[i].addr, vt[i].wdata, vt[i].wstrb);
                chk_resp("vec_wait", -1, 32'h0);
                tick();
            end
            memory_ready = 1'b1;
            memory_rdata = vt[i].rdata;
            @(negedge clk);
            chk_bus("vec_bus", 1'b1, vt[i].exp_instr, vt[i].addr, vt[i].wdata, vt[i].wstrb);
            chk_resp("vec_resp", vt[i].port, vt[i].exp_rdata);
            tick();
            memory_ready = 1'b0;
            memory_rdata = 32'h0;
        end

        do_reset();
        pulse(1, mk(1'b0, 32'h100, 32'h0, 4'h0));
        pulse(0, mk(1'b1, 32'h200, 32'h0, 4'h0));
        pulse(2, mk(1'b0, 32'h300, 32'h55, 4'hF));
        tick();
        clear_req();
        memory_ready = 1'b1;
        memory_rdata = 32'hD0;
        @(negedge clk);
        chk_bus("ord_d", 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        chk_resp("ord_d", 1, 32'hD0);
        tick();
        memory_rdata = 32'h10;
        @(negedge clk);
        chk_bus("ord_i", 1'b1, 1'b1, 32'h200, 32'h0, 4'h0);
        chk_resp("ord_i", 0, 32'h10);
        tick();
        memory_rdata = 32'hE0;
        @(negedge clk);
        chk_bus("ord_x", 1'b1, 1'b0, 32'h300, 32'h55, 4'hF);
        chk_resp("ord_x", 2, 32'hE0);
        tick();
        memory_ready = 1'b0;
        @(negedge clk);
        chk_bus("ord_end", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        do_reset();
        memory_ready = 1'b1;
        memory_rdata = 32'h1;
        pulse(0, mk(1'b1, 32'h8000, 32'h0, 4'h0));
        for (int k = 0; k <= 8; k++) begin
            pulse(1, mk(1'b0, 32'h100 + k, 32'h0, 4'h0));
            @(negedge clk);
            if (k > 0) chk_bus("starve_d", 1'b1, 1'b0, 32'h100 + k - 1, 32'h0, 4'h0);
            tick();
            imem_in = MEM_IN_IDLE;
        end
        dmem_in = MEM_IN_IDLE;
        @(negedge clk);
        chk_bus("starve_i", 1'b1, 1'b1, 32'h8000, 32'h0, 4'h0);
        chk_resp("starve_i", 0, 32'h1);
        tick();
        @(negedge clk);
        chk_bus("starve_d8", 1'b1, 1'b0, 32'h108, 32'h0, 4'h0);
        tick();
        memory_ready = 1'b0;

        do_reset();
        pulse(0, mk(1'b1, 32'h500, 32'h0, 4'h0));
        tick();
        clear_req();
        memory_rdata = 32'hBAD;
        for (int w = 0; w < 4; w++) begin
            memory_ready = (w == 3);
            flush_instr = (w == 0);
            @(negedge clk);
            chk_bus("flush_bus", 1'b1, 1'b1, 32'h500, 32'h0, 4'h0);
            chk_resp("flush_drop", -1, 32'h0);
            tick();
        end
        flush_instr = 1'b0;
        memory_ready = 1'b0;
        @(negedge clk);
        chk_bus("flush_idle", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        pulse(0, mk(1'b1, 32'h504, 32'h0, 4'h0));
        tick();
        clear_req();
        memory_ready = 1'b1;
        memory_rdata = 32'h600D;
        @(negedge clk);
        chk_bus("flush_next", 1'b1, 1'b1, 32'h504, 32'h0, 4'h0);
        chk_resp("flush_next", 0, 32'h600D);
        tick();
        memory_ready = 1'b0;

        do_reset();
        pulse(2, mk(1'b0, 32'h900, 32'h0, 4'h0));
        tick();
        clear_req();
        pulse(1, mk(1'b0, 32'h600, 32'h0, 4'h0));
        @(negedge clk);
        check("ovr_clear", overrun, 1'b0);
        tick();
        clear_req();
        pulse(1, mk(1'b0, 32'h700, 32'h0, 4'h0));
        tick();
        clear_req();
        memory_ready = 1'b1;
        memory_rdata = 32'h99;
        @(negedge clk);
        check("ovr_set", overrun, 1'b1);
        chk_bus("ovr_x", 1'b1, 1'b0, 32'h900, 32'h0, 4'h0);
        chk_resp("ovr_x", 2, 32'h99);
        tick();
        memory_rdata = 32'h66;
        @(negedge clk);
        chk_bus("ovr_first", 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
        chk_resp("ovr_first", 1, 32'h66);
        tick();
        memory_ready = 1'b0;
        @(negedge clk);
        chk_bus("ovr_second_absent", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("ovr_sticky", overrun, 1'b1);

        pulse(1, mk(1'b0, 32'hA00, 32'h1, 4'h1));
        tick();
        clear_req();
        @(negedge clk);
        chk_bus("rst_busy", 1'b1, 1'b0, 32'hA00, 32'h1, 4'h1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        memory_ready = 1'b1;
        memory_rdata = 32'hFF;
        @(negedge clk);
        check("rst_mid_bus", {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb}, 70'h0);
        check("rst_mid_overrun", overrun, 1'b0);
        chk_resp("rst_mid", -1, 32'h0);
        tick();
        @(negedge clk);
        chk_resp("rst_late", -1, 32'h0);
        chk_bus("rst_late", 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        do_reset();
        chk_model = 1'b1;
        for (int c = 0; c < 800; c++) begin
            imem_in = ($urandom_range(0, 2) == 0) ? mk(1'b1, $urandom, 32'h0, 4'h0) : MEM_IN_IDLE;
            dmem_in = ($urandom_range(0, 1) == 0) ? mk(1'b0, $urandom, $urandom, 4'($urandom)) : MEM_IN_IDLE;
            xmem_in = ($urandom_range(0, 3) == 0) ? mk(1'b0, $urandom, $urandom, 4'($urandom)) : MEM_IN_IDLE;
            flush_instr = ($urandom_range(0, 15) == 0);
            memory_ready = ($urandom_range(0, 2) != 0);
            memory_rdata = $urandom;
            rst = ($urandom_range(0, 63) != 0);
            tick();
        end
        clear_req();
        memory_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk_model = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
